// File: rtl/rvx_core_state_ctrl.sv
`default_nettype none
//============================================================================
// Module      : rvx_core_state_ctrl
// Description : Core-state FSM for the RVX core, stage 1. Sequences reset,
//               trap entry, trap return, WFI sleep and (optionally) debug
//               halt. Drives the flush/stall qualifiers consumed by
//               fetch/decode and the CSR unit.
//               Optional feature macro: RVX_CORE_STATE_DEBUG_EN enables the
//               debug HALTED state; without it halt_req/resume_req are
//               ignored and halted_s1 is tied low.
// Revision    : 1.0 - initial parametrised release
//============================================================================
module rvx_core_state_ctrl #(
    parameter int RESET_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clock_enable,
    input  logic       take_trap_s1,
    input  logic       mret_s1,
    input  logic       wfi_s1,
    input  logic       interrupt_pending,
    input  logic       halt_req,
    input  logic       resume_req,
    output logic [3:0] core_state_s1,
    output logic       flush_pipeline_s1,
    output logic       stall_pipeline_s1,
    output logic       halted_s1
);

    typedef enum logic [3:0] {
        RVX_STATE_RESET       = 4'd0,
        RVX_STATE_OPERATING   = 4'd1,
        RVX_STATE_TRAP_TAKEN  = 4'd2,
        RVX_STATE_TRAP_RETURN = 4'd3,
        RVX_STATE_WAIT_IRQ    = 4'd4,
        RVX_STATE_HALTED      = 4'd5
    } state_t;

    // Dwell counter reload values: a timed state lasting N cycles starts at N-1.
    localparam logic [CNT_WIDTH-1:0] RESET_LOAD = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] FLUSH_LOAD = CNT_WIDTH'(FLUSH_CYCLES - 1);

`ifdef RVX_CORE_STATE_DEBUG_EN
    localparam bit DEBUG_EN = 1'b1;
`else
    localparam bit DEBUG_EN = 1'b0;
`endif

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_next;

    // State and dwell counter register; everything holds while clock_enable is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RVX_STATE_RESET;
            cnt   <= RESET_LOAD;
        end else if (clock_enable) begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            // Timed states ignore all requests and leave once the counter drains.
            RVX_STATE_RESET,
            RVX_STATE_TRAP_TAKEN,
            RVX_STATE_TRAP_RETURN: begin
                if (cnt == '0) begin
                    state_next = RVX_STATE_OPERATING;
                end else begin
                    cnt_next = cnt - CNT_WIDTH'(1);
                end
            end
            RVX_STATE_OPERATING: begin
                if (take_trap_s1) begin
                    state_next = RVX_STATE_TRAP_TAKEN;
                    cnt_next   = FLUSH_LOAD;
                end else if (mret_s1) begin
                    state_next = RVX_STATE_TRAP_RETURN;
                    cnt_next   = FLUSH_LOAD;
                end else if (DEBUG_EN && halt_req) begin
                    state_next = RVX_STATE_HALTED;
                end else if (wfi_s1) begin
                    state_next = RVX_STATE_WAIT_IRQ;
                end
            end
            // Wake on any pending interrupt, even with mstatus.MIE clear.
            RVX_STATE_WAIT_IRQ: begin
                if (take_trap_s1) begin
                    state_next = RVX_STATE_TRAP_TAKEN;
                    cnt_next   = FLUSH_LOAD;
                end else if (interrupt_pending) begin
                    state_next = RVX_STATE_OPERATING;
                end else if (DEBUG_EN && halt_req) begin
                    state_next = RVX_STATE_HALTED;
                end
            end
            // Without debug support HALTED is just another illegal encoding.
            RVX_STATE_HALTED: begin
                if (!DEBUG_EN) begin
                    state_next = RVX_STATE_RESET;
                    cnt_next   = RESET_LOAD;
                end else if (resume_req && !halt_req) begin
                    state_next = RVX_STATE_OPERATING;
                end
            end
            default: begin
                state_next = RVX_STATE_RESET;
                cnt_next   = RESET_LOAD;
            end
        endcase
    end

    assign core_state_s1     = state;
    assign flush_pipeline_s1 = (state == RVX_STATE_RESET) ||
                               (state == RVX_STATE_TRAP_TAKEN) ||
                               (state == RVX_STATE_TRAP_RETURN);
    assign stall_pipeline_s1 = (state == RVX_STATE_WAIT_IRQ) ||
                               (DEBUG_EN && (state == RVX_STATE_HALTED));
    assign halted_s1         = DEBUG_EN && (state == RVX_STATE_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_rvx_core_state_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_rvx_core_state_ctrl
// Description : Self-checking bench for rvx_core_state_ctrl. Expected states
//               are queued as each cycle's stimulus is applied and compared
//               after the clock edge. Honours RVX_CORE_STATE_DEBUG_EN.
// Revision    : 1.0 - initial release
//============================================================================
module tb_rvx_core_state_ctrl;

    localparam int RESET_CYCLES = 3;
    localparam int FLUSH_CYCLES = 3;

    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_OP    = 4'd1;
    localparam logic [3:0] S_TT    = 4'd2;
    localparam logic [3:0] S_TR    = 4'd3;
    localparam logic [3:0] S_WAIT  = 4'd4;
    localparam logic [3:0] S_HALT  = 4'd5;

`ifdef RVX_CORE_STATE_DEBUG_EN
    localparam logic [3:0] S_HALT_EXP = S_HALT;
`else
    localparam logic [3:0] S_HALT_EXP = S_OP;
`endif

    logic       clock;
    logic       reset_n;
    logic       clock_enable;
    logic       take_trap_s1;
    logic       mret_s1;
    logic       wfi_s1;
    logic       interrupt_pending;
    logic       halt_req;
    logic       resume_req;
    logic [3:0] core_state_s1;
    logic       flush_pipeline_s1;
    logic       stall_pipeline_s1;
    logic       halted_s1;

    int         n_compared;
    int         n_mismatched;
    logic [3:0] exp_q[$];

    rvx_core_state_ctrl #(
        .RESET_CYCLES (RESET_CYCLES),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_WIDTH    (8)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .clock_enable      (clock_enable),
        .take_trap_s1      (take_trap_s1),
        .mret_s1           (mret_s1),
        .wfi_s1            (wfi_s1),
        .interrupt_pending (interrupt_pending),
        .halt_req          (halt_req),
        .resume_req        (resume_req),
        .core_state_s1     (core_state_s1),
        .flush_pipeline_s1 (flush_pipeline_s1),
        .stall_pipeline_s1 (stall_pipeline_s1),
        .halted_s1         (halted_s1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Check state and the qualifiers implied by it.
    task automatic check_outputs(input string tag, input logic [3:0] exp_state);
        logic exp_flush;
        logic exp_stall;
        logic exp_halt;
        exp_flush = (exp_state == S_RESET) || (exp_state == S_TT) || (exp_state == S_TR);
        exp_stall = (exp_state == S_WAIT) || (exp_state == S_HALT);
        exp_halt  = (exp_state == S_HALT);
        check({tag, ".state"},  core_state_s1,              exp_state);
        check({tag, ".flush"},  {3'b0, flush_pipeline_s1},  {3'b0, exp_flush});
        check({tag, ".stall"},  {3'b0, stall_pipeline_s1},  {3'b0, exp_stall});
        check({tag, ".halted"}, {3'b0, halted_s1},          {3'b0, exp_halt});
    endtask

    // Queue the expected post-edge state, advance one clock, then compare.
    task automatic cycle(input string tag, input logic [3:0] exp_state);
        logic [3:0] exp;
        exp_q.push_back(exp_state);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = exp_q.pop_front();
            check_outputs(tag, exp);
        end
    endtask

    task automatic clear_inputs();
        take_trap_s1      = 1'b0;
        mret_s1           = 1'b0;
        wfi_s1            = 1'b0;
        interrupt_pending = 1'b0;
        halt_req          = 1'b0;
        resume_req        = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        clear_inputs();
        clock_enable = 1'b1;
        reset_n      = 1'b0;

        // Reset state, checked before any clock edge.
        #2;
        check_outputs("reset", S_RESET);

        // Release reset; requests during RESET must be ignored.
        @(posedge clock);
        #1;
        reset_n      = 1'b1;
        take_trap_s1 = 1'b1;
        mret_s1      = 1'b1;
        wfi_s1       = 1'b1;
        for (int i = 0; i < RESET_CYCLES - 1; i++) cycle("reset_dwell", S_RESET);
        cycle("reset_exit", S_OP);
        clear_inputs();
        cycle("op_idle", S_OP);

        // Simultaneous trap and mret: trap wins; requests ignored while flushing.
        take_trap_s1 = 1'b1;
        mret_s1      = 1'b1;
        cycle("trap_vs_mret", S_TT);
        take_trap_s1 = 1'b0;
        wfi_s1       = 1'b1;
        for (int i = 0; i < FLUSH_CYCLES - 1; i++) cycle("trap_dwell", S_TT);
        cycle("trap_exit", S_OP);
        clear_inputs();

        // WFI then wake on pending interrupt.
        wfi_s1 = 1'b1;
        cycle("wfi_enter", S_WAIT);
        wfi_s1 = 1'b0;
        for (int i = 0; i < 4; i++) cycle("wfi_sleep", S_WAIT);
        interrupt_pending = 1'b1;
        cycle("wfi_irq_wake", S_OP);
        interrupt_pending = 1'b0;

        // WFI then trap.
        wfi_s1 = 1'b1;
        cycle("wfi_enter2", S_WAIT);
        wfi_s1 = 1'b0;
        for (int i = 0; i < 4; i++) cycle("wfi_sleep2", S_WAIT);
        take_trap_s1 = 1'b1;
        cycle("wfi_trap", S_TT);
        take_trap_s1 = 1'b0;
        for (int i = 0; i < FLUSH_CYCLES - 1; i++) cycle("wfi_trap_dwell", S_TT);
        cycle("wfi_trap_exit", S_OP);

        // Debug halt / resume (stays OPERATING without debug support).
        halt_req = 1'b1;
        cycle("halt_enter", S_HALT_EXP);
        resume_req = 1'b1;
        cycle("resume_with_halt", S_HALT_EXP);
        halt_req = 1'b0;
        cycle("resume", S_OP);
        resume_req = 1'b0;
`ifdef RVX_CORE_STATE_DEBUG_EN
        halt_req = 1'b1;
        cycle("halt_enter2", S_HALT);
        take_trap_s1 = 1'b1;
        cycle("halt_trap_ignored", S_HALT);
        clear_inputs();
        resume_req = 1'b1;
        cycle("resume2", S_OP);
        resume_req = 1'b0;
`endif

        // clock_enable low: a request is not acted on.
        clock_enable = 1'b0;
        take_trap_s1 = 1'b1;
        for (int i = 0; i < 2; i++) cycle("ce_off_op", S_OP);
        take_trap_s1 = 1'b0;
        clock_enable = 1'b1;

        // TRAP_RETURN with a 4-cycle freeze partway through.
        mret_s1 = 1'b1;
        cycle("mret_enter", S_TR);
        mret_s1 = 1'b0;
        cycle("tr_dwell_a", S_TR);
        clock_enable = 1'b0;
        for (int i = 0; i < 4; i++) cycle("tr_frozen", S_TR);
        clock_enable = 1'b1;
        for (int i = 0; i < FLUSH_CYCLES - 2; i++) cycle("tr_dwell_b", S_TR);
        cycle("tr_exit", S_OP);

        // Asynchronous reset between edges during TRAP_TAKEN.
        take_trap_s1 = 1'b1;
        cycle("trap_enter_async", S_TT);
        take_trap_s1 = 1'b0;
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs("async_reset", S_RESET);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < RESET_CYCLES - 1; i++) cycle("reset2_dwell", S_RESET);
        cycle("reset2_exit", S_OP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvx_core_state_ctrl.md
Name: rvx_core_state_ctrl

Overview:
- Parametrised core-state FSM for the RVX core. It supersedes the single-cycle reset/trap/return sequencer.
- Adds configurable reset and flush durations, a wait-for-interrupt (WFI) state, and an optional debug halt state.
- Sits in stage 1 of the core. It drives the pipeline flush and stall qualifiers consumed by fetch/decode and the CSR unit.

Parameters:
- RESET_CYCLES, 1: cycles spent in RESET after reset_n deasserts; legal range 1..255.
- FLUSH_CYCLES, 1: cycles spent in TRAP_TAKEN and in TRAP_RETURN; legal range 1..255.
- CNT_WIDTH, 8: width of the internal dwell counter; must satisfy 2^CNT_WIDTH > max(RESET_CYCLES, FLUSH_CYCLES).

Ports:
- clock  input  1  core clock
- reset_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clock
- clock_enable  input  1  when 0, state, counter and all registered outputs hold
- take_trap_s1  input  1  trap (exception or enabled interrupt) accepted this cycle
- mret_s1  input  1  MRET retiring this cycle
- wfi_s1  input  1  WFI retiring this cycle
- interrupt_pending  input  1  any interrupt pending (mip & mie), regardless of mstatus.MIE
- halt_req  input  1  debug halt request, level-sensitive
- resume_req  input  1  debug resume request, level-sensitive
- core_state_s1  output  4  current state encoding
- flush_pipeline_s1  output  1  pipeline flush qualifier
- stall_pipeline_s1  output  1  pipeline stall qualifier
- halted_s1  output  1  core is in debug halt

Behaviour:
- States:
  - existing RVX_STATE_RESET, RVX_STATE_OPERATING, RVX_STATE_TRAP_TAKEN, RVX_STATE_TRAP_RETURN;
  - new RVX_STATE_WAIT_IRQ = 4'd4 and RVX_STATE_HALTED = 4'd5, added to rvx_core_constants.vh.
- Reset (asynchronous): core_state_s1 = RESET; dwell counter = RESET_CYCLES-1; flush_pipeline_s1 = 1; stall_pipeline_s1 = 0; halted_s1 = 0.
- Dwell counter: loaded with N-1 on entry to a timed state, decremented each enabled cycle, state exits when the counter is 0.
  - RESET dwells exactly RESET_CYCLES enabled cycles.
  - TRAP_TAKEN and TRAP_RETURN each dwell exactly FLUSH_CYCLES enabled cycles.
- RESET: when the counter is 0, go to OPERATING. take_trap_s1, mret_s1 and wfi_s1 are ignored.
- OPERATING, priority high to low:
  1. take_trap_s1 -> TRAP_TAKEN
  2. mret_s1 -> TRAP_RETURN
  3. halt_req (debug build only) -> HALTED
  4. wfi_s1 -> WAIT_IRQ
  5. otherwise stay in OPERATING
- TRAP_TAKEN / TRAP_RETURN:
  - when the counter is 0, go to OPERATING;
  - all request inputs are ignored while in these states;
  - a trap and an mret in the same OPERATING cycle resolve to TRAP_TAKEN.
- WAIT_IRQ:
  - take_trap_s1 -> TRAP_TAKEN;
  - else interrupt_pending -> OPERATING (resume after WFI with interrupts globally masked);
  - else halt_req (debug build only) -> HALTED;
  - else stay in WAIT_IRQ.
- HALTED: take_trap_s1 is ignored. resume_req with halt_req low -> OPERATING. resume_req with halt_req high -> stay in HALTED.
- Illegal encodings (6..15): next state RESET, counter reloaded with RESET_CYCLES-1.
- Output decode (combinational from state):
  - flush_pipeline_s1 = state in {RESET, TRAP_TAKEN, TRAP_RETURN}
  - stall_pipeline_s1 = state in {WAIT_IRQ, HALTED}
  - halted_s1 = (state == HALTED)
  - flush and stall are never both 1.
- clock_enable = 0: no transition, no counter change, and inputs are not latched. Requests must be held by their sources until observed with clock_enable = 1.
- reset_n asserted mid-trap or mid-halt: immediate return to RESET with the counter reloaded; no pending request is remembered.

Optional Feature:
- Macro: RVX_CORE_STATE_DEBUG_EN.
- Defined: HALTED is reachable as specified above.
- Undefined:
  - halt_req and resume_req ports remain but are ignored;
  - halted_s1 is tied to 0;
  - HALTED is unreachable; if forced, it is treated as an illegal encoding.

Test Plan:
- RESET_CYCLES=3: release reset_n, clock_enable=1 -> flush_pipeline_s1 high for exactly 3 cycles, then core_state_s1 = OPERATING.
- FLUSH_CYCLES=2: in OPERATING, pulse take_trap_s1 and mret_s1 together for 1 cycle -> TRAP_TAKEN (not TRAP_RETURN) for exactly 2 cycles, then OPERATING.
- Pulse wfi_s1 -> WAIT_IRQ with stall_pipeline_s1 = 1. Raise interrupt_pending 5 cycles later -> OPERATING next cycle. Repeat with take_trap_s1 instead -> TRAP_TAKEN.
- Debug build: halt_req=1 in OPERATING -> HALTED and halted_s1 = 1. resume_req=1 with halt_req=1 -> stays HALTED. Drop halt_req -> OPERATING. Non-debug build: same stimulus -> stays in OPERATING, halted_s1 = 0.
- Hold clock_enable=0 for 4 cycles midway through a FLUSH_CYCLES=3 TRAP_RETURN -> state and counter frozen; total dwell is 3 enabled cycles.
- Assert reset_n low asynchronously (between edges) during TRAP_TAKEN -> core_state_s1 = RESET and flush_pipeline_s1 = 1 before the next clock edge.
